// File: rtl/default_value_skid_buffer_if.sv
// Handshake bundle for default_value_skid_buffer.
// Carries the per-channel producer side (i_valid/i_data in, o_ready out), the consumer side
// (o_valid/o_data out, i_ready in) and the per-channel occupancy o_count.
// Channel c occupies data bits [c*WIDTH +: WIDTH] and count bits [c*2 +: 2].
//   slave  : the buffer itself
//   master : the environment driving producers and consumers
interface default_value_skid_buffer_if #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned CH    = 2
);
    logic [CH-1:0]       i_valid;
    logic [CH-1:0]       o_ready;
    logic [CH*WIDTH-1:0] i_data;
    logic [CH-1:0]       o_valid;
    logic [CH-1:0]       i_ready;
    logic [CH*WIDTH-1:0] o_data;
    logic [CH*2-1:0]     o_count;

    modport slave (
        input  i_valid,
        input  i_data,
        input  i_ready,
        output o_ready,
        output o_valid,
        output o_data,
        output o_count
    );

    modport master (
        output i_valid,
        output i_data,
        output i_ready,
        input  o_ready,
        input  o_valid,
        input  o_data,
        input  o_count
    );
endinterface

// File: rtl/default_value_skid_buffer.sv
// CH independent registered valid/ready stages, each with a 2-entry skid buffer.
// An idle channel drives DEFAULT on its o_data slice so downstream always sees a defined word.
//
// Ports:
//   i_clk    rising-edge clock
//   i_rst_n  asynchronous active-low reset
//   bus      default_value_skid_buffer_if.slave: i_valid/i_data/o_ready (producer side),
//            o_valid/o_data/i_ready (consumer side), o_count (occupancy 0..2 per channel)
//
// Build option: define DEFAULT_VALUE_SKID_BUFFER_HOLD_LAST_EN to keep driving the last popped
// word on an empty channel instead of DEFAULT. Handshake and timing are unchanged.
module default_value_skid_buffer #(
    parameter int unsigned       WIDTH   = 8,
    parameter int unsigned       CH      = 2,
    parameter logic [WIDTH-1:0] DEFAULT = '0
) (
    input logic                      i_clk,
    input logic                      i_rst_n,
    default_value_skid_buffer_if.slave bus
);

    localparam logic [1:0] CntEmpty = 2'd0;
    localparam logic [1:0] CntOne   = 2'd1;
    localparam logic [1:0] CntTwo   = 2'd2;

    logic [1:0]       count_q [CH];
    logic [1:0]       count_d [CH];
    logic [WIDTH-1:0] head_q  [CH];
    logic [WIDTH-1:0] head_d  [CH];
    logic [WIDTH-1:0] skid_q  [CH];
    logic [WIDTH-1:0] skid_d  [CH];

    logic [CH-1:0] push;
    logic [CH-1:0] pop;

    // Handshakes use only registered ready/valid, so no input-to-output combinational path.
    always_comb begin
        push = '0;
        pop  = '0;
        for (int c = 0; c < CH; c++) begin
            push[c] = bus.i_valid[c] && (count_q[c] != CntTwo);
            pop[c]  = bus.i_ready[c] && (count_q[c] != CntEmpty);
        end
    end

    always_comb begin
        for (int c = 0; c < CH; c++) begin
            count_d[c] = count_q[c];
            head_d[c]  = head_q[c];
            skid_d[c]  = skid_q[c];
            case (count_q[c])
                CntEmpty: begin
                    if (push[c]) begin
                        head_d[c]  = bus.i_data[c*WIDTH +: WIDTH];
                        count_d[c] = CntOne;
                    end
                end
                CntOne: begin
                    if (push[c] && !pop[c]) begin
                        skid_d[c]  = bus.i_data[c*WIDTH +: WIDTH];
                        count_d[c] = CntTwo;
                    end else if (pop[c] && !push[c]) begin
                        // head_q is left alone so the hold-last build can keep showing it
                        count_d[c] = CntEmpty;
                    end else if (push[c] && pop[c]) begin
                        head_d[c]  = bus.i_data[c*WIDTH +: WIDTH];
                    end
                end
                CntTwo: begin
                    if (pop[c]) begin
                        head_d[c]  = skid_q[c];
                        count_d[c] = CntOne;
                    end
                end
                default: begin
                    count_d[c] = CntEmpty;
                end
            endcase
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int c = 0; c < CH; c++) begin
                count_q[c] <= CntEmpty;
                head_q[c]  <= DEFAULT;
                skid_q[c]  <= DEFAULT;
            end
        end else begin
            for (int c = 0; c < CH; c++) begin
                count_q[c] <= count_d[c];
                head_q[c]  <= head_d[c];
                skid_q[c]  <= skid_d[c];
            end
        end
    end

    // Outputs decode straight from the flops.
    always_comb begin
        bus.o_valid = '0;
        bus.o_ready = '0;
        bus.o_count = '0;
        bus.o_data  = '0;
        for (int c = 0; c < CH; c++) begin
            bus.o_valid[c]           = (count_q[c] != CntEmpty);
            bus.o_ready[c]           = (count_q[c] != CntTwo);
            bus.o_count[c*2 +: 2]    = count_q[c];
`ifdef DEFAULT_VALUE_SKID_BUFFER_HOLD_LAST_EN
            // head_q is DEFAULT out of reset and otherwise the newest head, popped or not.
            bus.o_data[c*WIDTH +: WIDTH] = head_q[c];
`else
            bus.o_data[c*WIDTH +: WIDTH] = (count_q[c] != CntEmpty) ? head_q[c] : DEFAULT;
`endif
        end
    end

endmodule

// File: tb/tb_default_value_skid_buffer.sv
// Directed bench for default_value_skid_buffer (CH=2, WIDTH=8, DEFAULT=8'hA5).
// Accepted words go into per-channel scoreboard queues; a monitor pops and compares on every
// consumer handshake. Directed checks cover reset, latency, backpressure, isolation and reset.
module tb_default_value_skid_buffer;

    localparam int unsigned WIDTH = 8;
    localparam int unsigned CH    = 2;
    localparam logic [7:0]  DEF   = 8'hA5;

`ifdef DEFAULT_VALUE_SKID_BUFFER_HOLD_LAST_EN
    localparam bit HOLD_LAST = 1'b1;
`else
    localparam bit HOLD_LAST = 1'b0;
`endif

    logic clk;
    logic rst_n;

    default_value_skid_buffer_if #(.WIDTH(WIDTH), .CH(CH)) bus ();

    default_value_skid_buffer #(
        .WIDTH   (WIDTH),
        .CH      (CH),
        .DEFAULT (DEF)
    ) dut (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .bus     (bus)
    );

    int checks;
    int errors;
    logic [7:0] q0 [$];
    logic [7:0] q1 [$];

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, required %h", name, act, exp);
        end
    endtask

    // Monitor: a pop happens at the next rising edge whenever o_valid & i_ready.
    initial begin
        forever begin
            @(negedge clk);
            if (rst_n) begin
                if (bus.o_valid[0] && bus.i_ready[0]) begin
                    if (q0.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL pop_ch0: got unexpected word %h, required none",
                                 bus.o_data[7:0]);
                    end else begin
                        chk("pop_ch0", {24'h0, bus.o_data[7:0]}, {24'h0, q0.pop_front()});
                    end
                end
                if (bus.o_valid[1] && bus.i_ready[1]) begin
                    if (q1.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL pop_ch1: got unexpected word %h, required none",
                                 bus.o_data[15:8]);
                    end else begin
                        chk("pop_ch1", {24'h0, bus.o_data[15:8]}, {24'h0, q1.pop_front()});
                    end
                end
            end
        end
    end

    // One cycle of stimulus, applied at posedge+1; returns which pushes were accepted.
    task automatic drive(input logic [1:0] v, input logic [15:0] d, input logic [1:0] r,
                         output logic [1:0] acc);
        bus.i_valid = v;
        bus.i_data  = d;
        bus.i_ready = r;
        @(negedge clk);
        acc = v & bus.o_ready & {2{rst_n}};
        if (acc[0]) q0.push_back(d[7:0]);
        if (acc[1]) q1.push_back(d[15:8]);
        @(posedge clk);
        #1;
        bus.i_valid = 2'b00;
        bus.i_data  = 16'hxxxx;
    endtask

    task automatic idle(input logic [1:0] r);
        logic [1:0] acc;
        drive(2'b00, 16'hxxxx, r, acc);
    endtask

    initial begin
        logic [1:0] acc;
        logic       got23;
        checks      = 0;
        errors      = 0;
        rst_n       = 1'b0;
        bus.i_valid = 2'b00;
        bus.i_data  = 16'h0000;
        bus.i_ready = 2'b00;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;

        // 1: reset values, held for 5 idle cycles
        for (int i = 0; i < 5; i++) begin
            chk("reset_valid", {30'h0, bus.o_valid}, 32'h0);
            chk("reset_ready", {30'h0, bus.o_ready}, 32'h3);
            chk("reset_count", {28'h0, bus.o_count}, 32'h0);
            chk("reset_data",  {16'h0, bus.o_data}, 32'h0000A5A5);
            idle(2'b00);
        end

        // 2: single push, one-cycle latency, then idle value
        drive(2'b01, 16'hxx11, 2'b11, acc);
        chk("single_valid", {30'h0, bus.o_valid}, 32'h1);
        chk("single_data",  {24'h0, bus.o_data[7:0]}, 32'h11);
        idle(2'b11);
        chk("single_empty_valid", {30'h0, bus.o_valid}, 32'h0);
        chk("single_empty_data", {24'h0, bus.o_data[7:0]}, HOLD_LAST ? 32'h11 : 32'hA5);

        // 3: ch1 backpressure, third word held until space frees
        drive(2'b10, 16'h21xx, 2'b01, acc);
        drive(2'b10, 16'h22xx, 2'b01, acc);
        chk("bp_count", {30'h0, bus.o_count[3:2]}, 32'h2);
        chk("bp_ready", {31'h0, bus.o_ready[1]}, 32'h0);
        drive(2'b10, 16'h23xx, 2'b01, acc);
        chk("bp_23_refused", {30'h0, acc}, 32'h0);
        chk("bp_head_stable", {24'h0, bus.o_data[15:8]}, 32'h21);
        got23 = 1'b0;
        for (int i = 0; i < 5 && !got23; i++) begin
            drive(2'b10, 16'h23xx, 2'b11, acc);
            got23 = acc[1];
        end
        chk("bp_23_accepted", {31'h0, got23}, 32'h1);
        repeat (3) idle(2'b11);
        chk("bp_drained_valid", {30'h0, bus.o_valid}, 32'h0);

        // 4: streaming 00..0F on ch0
        for (int i = 0; i < 16; i++) begin
            drive(2'b01, {8'h00, 8'(i)}, 2'b11, acc);
            chk($sformatf("stream_data_%0d", i), {24'h0, bus.o_data[7:0]}, i);
            chk("stream_valid", {31'h0, bus.o_valid[0]}, 32'h1);
            chk("stream_count", {30'h0, bus.o_count[1:0]}, 32'h1);
            chk("stream_ready", {31'h0, bus.o_ready[0]}, 32'h1);
        end
        idle(2'b11);
        chk("stream_end_valid", {30'h0, bus.o_valid}, 32'h0);

        // 5: ch0 stalled full while ch1 streams 30..33
        for (int i = 0; i < 4; i++) begin
            drive({1'b1, i < 2}, {8'(8'h30 + i), 8'(8'h40 + i)}, 2'b10, acc);
            chk($sformatf("iso_ch1_data_%0d", i), {24'h0, bus.o_data[15:8]}, 32'h30 + i);
            chk("iso_ch1_valid", {31'h0, bus.o_valid[1]}, 32'h1);
            chk("iso_ch0_head", {24'h0, bus.o_data[7:0]}, 32'h40);
            chk("iso_ch0_count", {30'h0, bus.o_count[1:0]}, (i == 0) ? 32'h1 : 32'h2);
        end
        repeat (3) idle(2'b11);

        // 6: asynchronous reset with both channels full
        drive(2'b11, 16'h6050, 2'b00, acc);
        drive(2'b11, 16'h6151, 2'b00, acc);
        chk("full_count", {28'h0, bus.o_count}, 32'ha);
        #2 rst_n = 1'b0;
        #1;
        chk("async_valid", {30'h0, bus.o_valid}, 32'h0);
        chk("async_ready", {30'h0, bus.o_ready}, 32'h3);
        chk("async_count", {28'h0, bus.o_count}, 32'h0);
        chk("async_data",  {16'h0, bus.o_data}, 32'h0000A5A5);
        q0.delete();
        q1.delete();
        @(posedge clk);
        #1 rst_n = 1'b1;
        drive(2'b01, 16'hxx55, 2'b11, acc);
        chk("post_reset_valid", {30'h0, bus.o_valid}, 32'h1);
        chk("post_reset_data", {24'h0, bus.o_data[7:0]}, 32'h55);
        repeat (2) idle(2'b11);

        chk("sb_empty_ch0", q0.size(), 32'h0);
        chk("sb_empty_ch1", q1.size(), 32'h0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete, required completion");
        $fatal(1);
    end

endmodule
